// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, ALU and result signals shared by the arbiter and its clients
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int FS_W   = 5
);
  logic              req0;
  logic [FS_W-1:0]   fs0;
  logic [DATA_W-1:0] s0;
  logic [DATA_W-1:0] t0;
  logic              req1;
  logic [FS_W-1:0]   fs1;
  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] t1;
  logic [FS_W-1:0]   alu_fs;
  logic [DATA_W-1:0] alu_s;
  logic [DATA_W-1:0] alu_t;
  logic [DATA_W-1:0] alu_y;
  logic              alu_n;
  logic              alu_z;
  logic              alu_v;
  logic              alu_c;
  logic [DATA_W-1:0] res_y;
  logic              res_n;
  logic              res_z;
  logic              res_v;
  logic              res_c;
  logic              done0;
  logic              done1;
  logic              busy;
  logic              ovf_trap;

  modport slave (
    input  req0, fs0, s0, t0, req1, fs1, s1, t1,
    input  alu_y, alu_n, alu_z, alu_v, alu_c,
    output alu_fs, alu_s, alu_t,
    output res_y, res_n, res_z, res_v, res_c,
    output done0, done1, busy, ovf_trap
  );

  modport master (
    output req0, fs0, s0, t0, req1, fs1, s1, t1,
    output alu_y, alu_n, alu_z, alu_v, alu_c,
    input  alu_fs, alu_s, alu_t,
    input  res_y, res_n, res_z, res_v, res_c,
    input  done0, done1, busy, ovf_trap
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin two-requester sequencer for a shared combinational ALU
// Optional overflow trap on ADD/SUB built when ALU_ARB_OVF_TRAP_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int FS_W   = 5
) (
  input logic           clk,
  input logic           reset,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_gnt;
  logic   r_gnt_id;
  logic   r_ovf;
  logic   w_any_req;
  logic   w_gnt_sel;

  assign w_any_req = bus.req0 | bus.req1;
  // Contention goes to whoever did not win last; otherwise the lone requester.
  assign w_gnt_sel = (bus.req0 & bus.req1) ? ~r_last_gnt : bus.req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_fs <= '0;
      bus.alu_s  <= '0;
      bus.alu_t  <= '0;
      bus.res_y  <= '0;
      bus.res_n  <= 1'b0;
      bus.res_z  <= 1'b0;
      bus.res_v  <= 1'b0;
      bus.res_c  <= 1'b0;
      r_last_gnt <= 1'b1;
      r_gnt_id   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        bus.alu_fs <= w_gnt_sel ? bus.fs1 : bus.fs0;
        bus.alu_s  <= w_gnt_sel ? bus.s1  : bus.s0;
        bus.alu_t  <= w_gnt_sel ? bus.t1  : bus.t0;
        r_gnt_id   <= w_gnt_sel;
        r_last_gnt <= w_gnt_sel;
      end
      if (r_state == S_EXEC) begin
        bus.res_y <= bus.alu_y;
        bus.res_n <= bus.alu_n;
        bus.res_z <= bus.alu_z;
        bus.res_v <= bus.alu_v;
        bus.res_c <= bus.alu_c;
`ifdef ALU_ARB_OVF_TRAP_EN
        r_ovf <= bus.alu_v && (bus.alu_fs == 5'h02 || bus.alu_fs == 5'h03);
`else
        r_ovf <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    bus.busy     = (r_state != S_IDLE);
    bus.done0    = (r_state == S_DONE) && !r_gnt_id;
    bus.done1    = (r_state == S_DONE) &&  r_gnt_id;
    bus.ovf_trap = (r_state == S_DONE) && r_ovf;
  end
endmodule
